// File: rtl/pc_source_unit.sv
`timescale 1ns/1ps
// PC source mux and PC/EPC registers with misaligned-target trap; loads visible one cycle after load_req.
// pc_next/sel_err are zero-latency combinational; no back-pressure, control holds each load for one cycle.
module pc_source_unit #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_SRC    = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = '0,
    parameter int                ALIGN_BITS = 2,
    localparam int               SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic                      pc_write,
    input  logic                      pc_write_cond,
    input  logic                      cond_true,
    input  logic                      epc_capture,
    output logic [DATA_W-1:0]         pc_next,
    output logic [DATA_W-1:0]         pc_out,
    output logic [DATA_W-1:0]         epc_out,
    output logic                      sel_err,
    output logic                      misalign_fault,
    output logic                      fault_active,
    output logic [7:0]                fault_count
);

    localparam logic [0:0]       ST_RUN    = 1'b0;
    localparam logic [0:0]       ST_FAULT  = 1'b1;
    localparam logic [SEL_W:0]   SRC_LIMIT = (SEL_W+1)'(NUM_SRC);

    logic [DATA_W-1:0] slot [NUM_SRC];
    logic [0:0]        state;
    logic              load_req;
    logic              misaligned;
    logic              vector_load;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        assign slot[g] = src_bus[g*DATA_W +: DATA_W];
    end

    // Out-of-range selects fall back to the exception vector in slot 0.
    always_comb begin
        pc_next = slot[0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                pc_next = slot[i];
            end
        end
    end

    assign sel_err  = ({1'b0, src_sel} >= SRC_LIMIT);
    assign load_req = pc_write | (pc_write_cond & cond_true);

    if (ALIGN_BITS > 0) begin : g_align
        assign misaligned = |pc_next[ALIGN_BITS-1:0];
    end else begin : g_noalign
        assign misaligned = 1'b0;
    end

    // With src_sel == 0, pc_next is slot 0, so misaligned also covers the vector itself.
    assign vector_load  = load_req & (src_sel == '0) & ~misaligned;
    assign fault_active = (state == ST_FAULT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            pc_out         <= RESET_PC;
            epc_out        <= '0;
            misalign_fault <= 1'b0;
            fault_count    <= 8'd0;
        end else begin
            misalign_fault <= 1'b0;
            if (epc_capture) begin
                epc_out <= pc_out;
            end
            case (state)
                ST_RUN: begin
                    if (load_req) begin
                        if (!misaligned) begin
                            pc_out <= pc_next;
                        end else begin
                            epc_out        <= pc_out;
                            misalign_fault <= 1'b1;
                            state          <= ST_FAULT;
                            if (fault_count != 8'hFF) begin
                                fault_count <= fault_count + 8'd1;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    if (vector_load) begin
                        pc_out <= slot[0];
                        state  <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_source_unit.md
# pc_source_unit

Parametrised program-counter source unit for the multicycle datapath. It selects the next PC from NUM_SRC candidate buses and holds the PC register with plain and conditional write enables. It also captures EPC, and traps misaligned targets by holding the PC and waiting for a redirect to the exception vector. It sits between the ALU/shift/EPC/exception-vector outputs and the instruction-address path, under control of the main control FSM.

## Interface
- DATA_W, 32, width of PC and every source bus
- NUM_SRC, 4, number of candidate sources (2..8); slot 0 is always the exception vector
- SEL_W, $clog2(NUM_SRC), select width (derived, not overridden)
- RESET_PC, 0, PC value after reset
- ALIGN_BITS, 2, low PC bits that must be zero for a legal target
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- src_sel  in  SEL_W  source select
- src_bus  in  NUM_SRC*DATA_W  flattened sources, slot i at [i*DATA_W +: DATA_W]
- pc_write  in  1  unconditional PC load
- pc_write_cond  in  1  conditional PC load (branch)
- cond_true  in  1  branch condition, qualifies pc_write_cond
- epc_capture  in  1  load EPC with current PC
- pc_next  out  DATA_W  combinational selected source
- pc_out  out  DATA_W  registered PC
- epc_out  out  DATA_W  registered EPC
- sel_err  out  1  combinational, src_sel >= NUM_SRC
- misalign_fault  out  1  registered one-cycle fault pulse
- fault_active  out  1  high while in FAULT state
- fault_count  out  8  saturating count of misalign faults

## Operation
- Selection: pc_next = slot[src_sel]. If src_sel >= NUM_SRC, pc_next = slot 0 and sel_err = 1.
- load_req = pc_write | (pc_write_cond & cond_true).
- misaligned = (pc_next[ALIGN_BITS-1:0] != 0). With ALIGN_BITS = 0 nothing is ever misaligned.
- FSM, two states, reset to RUN:
  - RUN, load_req & !misaligned: pc_out <= pc_next.
  - RUN, load_req & misaligned: pc_out holds, epc_out <= pc_out, misalign_fault pulses, fault_count increments (saturates at 255), go to FAULT.
  - RUN, no load_req: hold.
  - FAULT: every load_req is ignored unless src_sel == 0 and slot 0 is aligned. That load sets pc_out <= slot 0 and returns to RUN.
  - FAULT, src_sel == 0 load with misaligned slot 0: stay in FAULT, no new pulse, count unchanged.
- EPC: epc_capture loads epc_out <= pc_out in either state. The value captured is the pre-edge PC, even when the PC loads on the same edge.
- Simultaneous epc_capture and misalign trap: both write the same pre-edge PC, with no conflict.
- Reset (async, any time, including mid-FAULT): pc_out = RESET_PC, epc_out = 0, misalign_fault = 0, fault_active = 0, fault_count = 0, state RUN.

## Timing
- pc_next and sel_err are pure combinational from src_sel and src_bus, with zero latency.
- A PC load is visible on pc_out one cycle after load_req is sampled high.
- misalign_fault is high for exactly the one cycle after the trapping edge. fault_active rises on that same edge.
- Leaving FAULT: fault_active falls on the edge that loads the vector.
- fault_count updates on the trapping edge.
- EPC is visible one cycle after epc_capture.
- No handshake or back-pressure. Control must hold its signals for one cycle per load.

## Test plan
- Reset, then pc_write with src_sel=2 and slot2=0x0000_0040 -> pc_out=0x40 next cycle; epc_out=0, misalign_fault=0.
- pc_write_cond=1 with cond_true=0 and slot3=0x100 -> pc_out holds. With cond_true=1 -> pc_out=0x100.
- pc_out=0x40, pc_write with src_sel=2 and slot2=0x42 -> pc_out stays 0x40, epc_out=0x40, one-cycle misalign_fault, fault_count=1, fault_active=1.
  - Then pc_write with src_sel=1 -> ignored.
  - Then pc_write with src_sel=0 and slot0=0x8000_0180 -> pc_out=0x8000_0180, fault_active=0.
- NUM_SRC=3, src_sel=3 -> sel_err=1 and pc_next=slot0.
- epc_capture and pc_write on the same edge with pc_out=0x20 and target 0x24 -> epc_out=0x20, pc_out=0x24.
- Assert reset_n low mid-FAULT, asynchronously between edges -> all outputs immediately at reset values (pc_out=RESET_PC); 256 traps leave fault_count at 255.
